// File: rtl/alu_issue_sequencer_pkg.sv
// Shared opcode encodings, legality check and pipeline stage records for the
// ALU issue sequencer.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_ID_W   = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b110;

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ: is_legal_op = 1'b1;
            default:                               is_legal_op = 1'b0;
        endcase
    endfunction

    // Control part of a stage record; it travels through all three stages.
    typedef struct packed {
        logic                valid;
        logic                port;
        logic [ALU_ID_W-1:0] id;
        logic [2:0]          op;
        logic                err;
    } tag_t;

    // Operands are dropped once the ALU has consumed them.
    typedef struct packed {
        tag_t                  tag;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } s1_t;

    typedef struct packed {
        tag_t                  tag;
        logic [ALU_DATA_W-1:0] b;
    } s2_t;

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Request, response and ALU-side signals of the issue sequencer; master is the
// requester/ALU side, slave is the sequencer.
interface alu_issue_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 16
);
    logic              req0_valid, req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [ID_W-1:0]   req0_id;
    logic              req1_valid, req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [ID_W-1:0]   req1_id;
    logic              flush;
    logic              rsp_valid, rsp_port, rsp_eq, rsp_err;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic [DATA_W-1:0] alu_inp_1, alu_inp_2, alu_result;
    logic [2:0]        alu_op;
    logic              alu_zero;
    logic [CNT_W-1:0]  issue_cnt;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_id,
        output req1_valid, req1_op, req1_a, req1_b, req1_id,
        output flush, alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_port, rsp_id, rsp_result, rsp_eq, rsp_err,
        input  alu_inp_1, alu_inp_2, alu_op, issue_cnt
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_id,
        input  req1_valid, req1_op, req1_a, req1_b, req1_id,
        input  flush, alu_result, alu_zero,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_port, rsp_id, rsp_result, rsp_eq, rsp_err,
        output alu_inp_1, alu_inp_2, alu_op, issue_cnt
    );
endinterface

// File: rtl/alu_issue_sequencer_rr_arbiter2.sv
// Two-port round-robin grant; the pointer names the port that wins a tie and
// moves to the loser after every grant.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_block,
    output logic o_gnt0,
    output logic o_gnt1,
    output logic o_accept,
    output logic o_winner
);
    logic r_ptr;
    logic w_pick1;

    assign w_pick1  = i_req1 & (~i_req0 | r_ptr);
    assign o_gnt0   = i_req0 & ~w_pick1 & ~i_block;
    assign o_gnt1   = w_pick1 & ~i_block;
    assign o_accept = o_gnt0 | o_gnt1;
    assign o_winner = w_pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (o_accept) begin
            r_ptr <= ~w_pick1;
        end
    end
endmodule

// File: rtl/alu_issue_sequencer.sv
// Shares one pipelined ALU between the EX stage (port 0) and the branch unit
// (port 1), skewing operands to the ALU timing and tagging fixed-latency results.
module alu_issue_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int ID_W   = ALU_ID_W,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst_n,
    alu_issue_sequencer_if.slave bus
);
    logic             w_accept, w_winner, w_gnt0, w_gnt1;
    s1_t              w_new, r_s1;
    s2_t              r_s2;
    tag_t             r_s3;
    logic             w_s2_issue, w_s3_ok, w_s3_beq;
    logic [CNT_W-1:0] r_issue_cnt;
    logic [ID_W-1:0]  w_req_id;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req0   (bus.req0_valid),
        .i_req1   (bus.req1_valid),
        .i_block  (bus.flush),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1),
        .o_accept (w_accept),
        .o_winner (w_winner)
    );

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign w_req_id       = w_winner ? bus.req1_id : bus.req0_id;

    always_comb begin
        w_new           = '0;
        w_new.tag.valid = w_accept;
        w_new.tag.port  = w_winner;
        w_new.tag.id    = w_req_id;
        w_new.tag.op    = w_winner ? bus.req1_op : bus.req0_op;
        w_new.a         = w_winner ? bus.req1_a  : bus.req0_a;
        w_new.b         = w_winner ? bus.req1_b  : bus.req0_b;
        w_new.tag.err   = ~is_legal_op(w_new.tag.op);
    end

    // NOTE: the payload is reset along with valid so every ALU-facing and
    // response output is a clean 0 the moment rst_n falls, not just after a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_s1           <= w_new;
            r_s2.tag       <= r_s1.tag;
            r_s2.tag.valid <= r_s1.tag.valid & ~bus.flush;
            r_s2.b         <= r_s1.b;
            r_s3           <= r_s2.tag;
            r_s3.valid     <= r_s2.tag.valid & ~bus.flush;
            if (w_accept) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.issue_cnt = r_issue_cnt;

    // Illegal ops ride the pipeline for their error response but never reach the ALU.
    assign w_s2_issue    = r_s2.tag.valid & ~r_s2.tag.err;
    assign bus.alu_inp_1 = r_s1.tag.valid ? r_s1.a : '0;
    assign bus.alu_inp_2 = w_s2_issue ? r_s2.b : '0;
    assign bus.alu_op    = w_s2_issue ? r_s2.tag.op : OP_NOP;

    // The ALU leaves its result stale on beq, so only the zero flag is used there.
    assign w_s3_ok        = r_s3.valid & ~r_s3.err;
    assign w_s3_beq       = w_s3_ok & (r_s3.op == OP_BEQ);
    assign bus.rsp_valid  = r_s3.valid;
    assign bus.rsp_port   = r_s3.valid & r_s3.port;
    assign bus.rsp_id     = r_s3.valid ? r_s3.id : '0;
    assign bus.rsp_result = (w_s3_ok & ~w_s3_beq) ? bus.alu_result : '0;
    assign bus.rsp_eq     = w_s3_beq & ~bus.alu_zero;
    assign bus.rsp_err    = r_s3.valid & r_s3.err;
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized bench for alu_issue_sequencer: an ALU stand-in plus a per-cycle
// expectation model derived from accept cycle, operands and flush/reset events.
module tb_alu_issue_sequencer;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int CW = 4;

    typedef struct packed {
        bit          v;
        bit [2:0]    op;
        bit [DW-1:0] a;
        bit [DW-1:0] b;
        bit [IW-1:0] id;
    } req_t;

    typedef struct packed {
        bit          port;
        bit [IW-1:0] id;
        bit [DW-1:0] result;
        bit          eq;
        bit          err;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_sequencer_if #(.DATA_W(DW), .ID_W(IW), .CNT_W(CW)) bus ();

    alu_issue_sequencer #(.DATA_W(DW), .ID_W(IW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ALU stand-in: inp_1 registered one edge ahead, result/zero registered on the next.
    logic [DW-1:0] alu_a_q   = '0;
    logic [DW-1:0] alu_res_q = '0;
    logic          alu_z_q   = 1'b0;
    assign bus.alu_result = alu_res_q;
    assign bus.alu_zero   = alu_z_q;

    always @(posedge clk) begin
        alu_a_q <= bus.alu_inp_1;
        if (bus.alu_op != 3'b000) alu_z_q <= (alu_a_q != bus.alu_inp_2);
        case (bus.alu_op)
            3'b001:  alu_res_q <= alu_a_q + bus.alu_inp_2;
            3'b010:  alu_res_q <= alu_a_q - bus.alu_inp_2;
            3'b011:  alu_res_q <= alu_a_q & bus.alu_inp_2;
            3'b100:  alu_res_q <= alu_a_q | bus.alu_inp_2;
            default: alu_res_q <= alu_res_q;
        endcase
    end

    rsp_t        exp_rsp [int];
    bit [DW-1:0] exp_i1  [int];
    bit [DW-1:0] exp_i2  [int];
    bit [2:0]    exp_op  [int];
    bit          m_ptr;
    int unsigned m_cnt;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic req_t mk(input bit v, input bit [2:0] op, input bit [DW-1:0] a,
                                input bit [DW-1:0] b, input bit [IW-1:0] id);
        mk = '{v: v, op: op, a: a, b: b, id: id};
    endfunction

    function automatic rsp_t ref_rsp(input bit port, input req_t r);
        ref_rsp      = '0;
        ref_rsp.port = port;
        ref_rsp.id   = r.id;
        case (r.op)
            3'b001:  ref_rsp.result = r.a + r.b;
            3'b010:  ref_rsp.result = r.a - r.b;
            3'b011:  ref_rsp.result = r.a & r.b;
            3'b100:  ref_rsp.result = r.a | r.b;
            3'b110:  ref_rsp.eq     = (r.a == r.b);
            default: ref_rsp.err    = 1'b1;
        endcase
    endfunction

    task automatic check_outputs();
        rsp_t e = '0;
        bit   ev = exp_rsp.exists(cyc);
        if (ev) e = exp_rsp[cyc];
        check("rsp_valid",  bus.rsp_valid,  ev);
        check("rsp_port",   bus.rsp_port,   e.port);
        check("rsp_id",     bus.rsp_id,     e.id);
        check("rsp_result", bus.rsp_result, e.result);
        check("rsp_eq",     bus.rsp_eq,     e.eq);
        check("rsp_err",    bus.rsp_err,    e.err);
        check("alu_inp_1",  bus.alu_inp_1,  exp_i1.exists(cyc) ? exp_i1[cyc] : '0);
        check("alu_inp_2",  bus.alu_inp_2,  exp_i2.exists(cyc) ? exp_i2[cyc] : '0);
        check("alu_op",     bus.alu_op,     exp_op.exists(cyc) ? exp_op[cyc] : 3'b000);
        check("issue_cnt",  bus.issue_cnt,  m_cnt);
    endtask

    task automatic drive(input req_t r0, input req_t r1, input bit fl);
        bus.req0_valid = r0.v; bus.req0_op = r0.op; bus.req0_a = r0.a;
        bus.req0_b     = r0.b; bus.req0_id = r0.id;
        bus.req1_valid = r1.v; bus.req1_op = r1.op; bus.req1_a = r1.a;
        bus.req1_b     = r1.b; bus.req1_id = r1.id;
        bus.flush      = fl;
    endtask

    task automatic step(input req_t r0, input req_t r1, input bit fl);
        bit   e0 = 1'b0;
        bit   e1 = 1'b0;
        req_t w;
        @(negedge clk);
        check_outputs();
        drive(r0, r1, fl);
        #1;
        if (!fl) begin
            if (r0.v && r1.v) begin
                e0 = !m_ptr;
                e1 = m_ptr;
            end else begin
                e0 = r0.v;
                e1 = r1.v;
            end
        end
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);
        if (e0 || e1) begin
            w = e1 ? r1 : r0;
            exp_i1[cyc + 1]  = w.a;
            exp_rsp[cyc + 3] = ref_rsp(e1, w);
            if (!exp_rsp[cyc + 3].err) begin
                exp_i2[cyc + 2] = w.b;
                exp_op[cyc + 2] = w.op;
            end
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_ptr = !e1;
        end
        if (fl) begin
            for (int k = 1; k <= 3; k++) begin
                exp_rsp.delete(cyc + k);
                exp_i1.delete(cyc + k);
                exp_i2.delete(cyc + k);
                exp_op.delete(cyc + k);
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_outputs();
        drive('0, '0, 1'b0);
        rst_n = 1'b0;
        exp_rsp.delete();
        exp_i1.delete();
        exp_i2.delete();
        exp_op.delete();
        m_ptr = 1'b0;
        m_cnt = 0;
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc += 3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    initial begin
        req_t r0, r1;
        drive('0, '0, 1'b0);
        m_ptr = 1'b0;
        m_cnt = 0;
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // add 5+3 on port 0
        step(mk(1, 3'b001, 5, 3, 2), '0, 1'b0);
        idle(4);
        // beq equal then unequal on port 1
        step('0, mk(1, 3'b110, 7, 7, 1), 1'b0);
        step('0, mk(1, 3'b110, 7, 9, 3), 1'b0);
        idle(4);
        // both ports contending for 4 cycles
        for (int i = 0; i < 4; i++)
            step(mk(1, 3'b010, 10, 4, 4'(i)), mk(1, 3'b100, 32'hF0, 32'h0F, 4'(8 + i)), 1'b0);
        idle(4);
        // illegal opcode
        step(mk(1, 3'b111, 32'hDEAD, 32'hBEEF, 5), '0, 1'b0);
        idle(4);
        // three adds then flush with a request pending
        for (int i = 0; i < 3; i++) step(mk(1, 3'b001, 32'(i), 100, 4'(i)), '0, 1'b0);
        step(mk(1, 3'b001, 1, 1, 9), mk(1, 3'b011, 3, 1, 9), 1'b1);
        idle(4);
        // reset mid-flight, then one op afterwards
        step(mk(1, 3'b001, 11, 22, 6), '0, 1'b0);
        step('0, mk(1, 3'b010, 50, 8, 7), 1'b0);
        do_reset();
        step(mk(1, 3'b011, 32'hFF00, 32'h0FF0, 10), '0, 1'b0);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            r0 = mk($urandom_range(0, 9) < 7, 3'($urandom), $urandom, $urandom, 4'($urandom));
            r1 = mk($urandom_range(0, 9) < 7, 3'($urandom), $urandom, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) r0.b = r0.a;
            if ($urandom_range(0, 2) == 0) r1.b = r1.a;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(r0, r1, $urandom_range(0, 19) == 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
